// File: rtl/ps2_key_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_ps2_pkg
// Brief    : Shared PS/2 receiver types, prefix bytes and game key scan codes.
// Revision : 1.0 - initial release
// ============================================================================
package tetris_ps2_pkg;

    // Bit-level receiver states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // Scan code set 2 prefix bytes.
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Game keys; the arrow codes arrive behind an E0 prefix.
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder_if
// Brief    : PS/2 pin pair plus decoded key event bus.
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_key_decoder_if;

    logic       ps2Clk;
    logic       ps2Data;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       extended;
    logic       frameError;

    // Decoder side: samples the pins, produces key events.
    modport master (
        input  ps2Clk,
        input  ps2Data,
        output valid,
        output makeBreak,
        output outCode,
        output extended,
        output frameError
    );

    // Keyboard / consumer side.
    modport slave (
        output ps2Clk,
        output ps2Data,
        input  valid,
        input  makeBreak,
        input  outCode,
        input  extended,
        input  frameError
    );

endinterface
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_frame_rx
// Brief    : PS/2 bit-level receiver: synchronizers, frame FSM, odd parity
//            and stop-bit check, inactivity timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import tetris_ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       ps2Clk,
    input  wire logic       ps2Data,
    output logic      [7:0] rxByte,
    output logic            byteValid,
    output logic            frameError
);

    localparam int                 c_TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic               r_clk_s1, r_clk_s2, r_clk_s3;
    logic               r_dat_s1, r_dat_s2;
    rx_state_t          r_state, w_next_state;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic [c_TMO_W-1:0] r_tmo;
    logic               w_fall;
    logic               w_timeout;
    logic               w_accept;
    logic               w_reject;

    // Falling edge of the synchronized keyboard clock.
    assign w_fall    = ~r_clk_s2 & r_clk_s3;
    // A fall in the same cycle restarts the window instead of aborting.
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_tmo == c_TMO_LAST);
    assign rxByte    = r_shift;

    // Two-stage synchronizers plus one edge-detect stage; idle bus is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_clk_s3 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2Clk;
            r_clk_s2 <= r_clk_s1;
            r_clk_s3 <= r_clk_s2;
            r_dat_s1 <= ps2Data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic: advance only on keyboard clock falls.
    always_comb begin
        w_next_state = r_state;
        if (w_timeout) begin
            w_next_state = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   if (!r_dat_s2) w_next_state = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_next_state = ST_PARITY;
                ST_PARITY: w_next_state = ST_STOP;
                ST_STOP:   w_next_state = ST_IDLE;
                default:   w_next_state = ST_IDLE;
            endcase
        end
    end

    // Stop-bit verdict: good stop bit and odd parity over data plus parity.
    always_comb begin
        w_accept = 1'b0;
        w_reject = 1'b0;
        if (r_state == ST_STOP && w_fall) begin
            if (r_dat_s2 && (^{r_shift, r_parity})) w_accept = 1'b1;
            else                                     w_reject = 1'b1;
        end
    end

    // Shift register, bit counter, timeout counter and registered pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_parity   <= 1'b0;
            r_tmo      <= '0;
            byteValid  <= 1'b0;
            frameError <= 1'b0;
        end else begin
            byteValid  <= w_accept;
            frameError <= w_reject | w_timeout;

            if (w_fall || w_timeout || r_state == ST_IDLE) r_tmo <= '0;
            else                                           r_tmo <= r_tmo + c_TMO_W'(1);

            if (w_timeout) begin
                r_bit_cnt <= 3'd0;
            end else if (w_fall) begin
                case (r_state)
                    ST_IDLE: r_bit_cnt <= 3'd0;
                    ST_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    ST_PARITY: r_parity <= r_dat_s2;
                    default:   r_bit_cnt <= 3'd0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_decoder
// Brief    : PS/2 keyboard decoder; folds E0/F0 prefixes into one key event
//            with make/break and extended flags.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import tetris_ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic         clk,
    input  wire logic         reset,
    ps2_key_decoder_if.master bus
);

    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_error;
    logic       r_brk;
    logic       r_ext;
    logic       r_valid;
    logic       r_make_break;
    logic [7:0] r_out_code;
    logic       r_extended;
    logic       r_frame_error;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2Clk     (bus.ps2Clk),
        .ps2Data    (bus.ps2Data),
        .rxByte     (w_rx_byte),
        .byteValid  (w_rx_valid),
        .frameError (w_rx_error)
    );

    assign bus.valid      = r_valid;
    assign bus.makeBreak  = r_make_break;
    assign bus.outCode    = r_out_code;
    assign bus.extended   = r_extended;
    assign bus.frameError = r_frame_error;

    // Prefix tracking and event output; an error drops any pending prefix.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_brk         <= 1'b0;
            r_ext         <= 1'b0;
            r_valid       <= 1'b0;
            r_make_break  <= 1'b0;
            r_out_code    <= 8'h00;
            r_extended    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_valid       <= 1'b0;
            r_frame_error <= w_rx_error;
            if (w_rx_error) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_rx_valid) begin
                case (w_rx_byte)
                    PS2_EXT: r_ext <= 1'b1;
                    PS2_BRK: r_brk <= 1'b1;
                    default: begin
                        r_valid      <= 1'b1;
                        r_out_code   <= w_rx_byte;
                        r_make_break <= ~r_brk;
                        r_extended   <= r_ext;
                        r_brk        <= 1'b0;
                        r_ext        <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the clk cycles without a ps2_clk falling edge that abort a partial frame.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-004 SHALL have port ps2Clk, input, 1, keyboard clock, asynchronous to clk.
REQ-005 SHALL have port ps2Data, input, 1, keyboard data, asynchronous to clk.
REQ-006 SHALL have port valid, output, 1, one-cycle pulse when a complete key event is decoded.
REQ-007 SHALL have port makeBreak, output, 1, 1 = make (press), 0 = break (release).
REQ-008 SHALL have port outCode, output, 8, scan code of the last decoded event.
REQ-009 SHALL have port extended, output, 1, set when the last event carried an E0 prefix.
REQ-010 SHALL have port frameError, output, 1, one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-011 SHALL pass ps2Clk and ps2Data through 2-FF synchronizers, plus one extra ps2Clk stage for edge detection; a fall is sync2 = 0 with sync3 = 1.
REQ-012 SHALL run the receiver FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on detected falls.
REQ-013 SHALL, in IDLE, enter DATA on a fall with data = 0 and stay in IDLE on a fall with data = 1.
REQ-014 SHALL, in DATA, shift 8 bits LSB first using a 3-bit counter, then enter PARITY after the 8th bit.
REQ-015 SHALL, in PARITY, capture the parity bit, then enter STOP.
REQ-016 SHALL, in STOP, accept the byte only when stop = 1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity).
REQ-017 SHALL, when it accepts a byte, pulse the internal byteValid for 1 cycle.
REQ-018 SHALL, when it rejects a byte, pulse frameError for 1 cycle and clear the pending brk and ext flags.
REQ-019 SHALL clear the timeout counter on every fall.
REQ-020 SHALL, outside IDLE, return to IDLE when the timeout counter reaches TIMEOUT_CYCLES-1; it then discards the partial byte, pulses frameError and clears brk and ext.
REQ-021 SHALL size the timeout counter at $clog2(TIMEOUT_CYCLES) bits and never let it wrap.
REQ-022 SHALL decode each accepted byte as follows.
- E0: set ext; no valid.
- F0: set brk; no valid.
- Any other byte: register valid = 1, outCode = byte, makeBreak = ~brk, extended = ext, then clear brk and ext.
REQ-023 SHALL give prefix bytes no output effect in either order (E0 F0 or F0 E0).
REQ-024 SHALL hold outCode, makeBreak and extended stable between valid pulses.
REQ-025 SHALL assert valid exactly 1 cycle per non-prefix byte; the rising edge of valid follows the 4th clk rising edge after the stop-bit fall on the pin.
REQ-026 SHALL keep valid and frameError mutually exclusive in any cycle.

Reset
REQ-027 SHALL, while reset = 0 at a clk edge, set the following.
- FSM to IDLE.
- Bit counter and timeout counter to 0.
- brk and ext to 0.
- valid, makeBreak, extended and frameError to 0, and outCode to 8'h00.
- Synchronizer stages to 1 (bus idle).
REQ-028 SHALL, after reset mid-frame, ignore the remaining bits of that frame until a new start bit is seen from IDLE.

Structure
REQ-029 SHALL place the following in shared package tetris_ps2_pkg.
- Receiver state enum.
- Constants PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0.
- Game key codes: W 8'h1D, A 8'h1C, S 8'h1B, D 8'h23, arrows E0-75/6B/72/74.
REQ-030 SHALL split the bit-level receiver (synchronizers, FSM, timeout, parity) into sub-module ps2_frame_rx, which outputs byte[7:0], byteValid and frameError; prefix decoding stays in ps2_key_decoder.

Verification
REQ-031 SHALL check frame 0x1D (parity 1) -> exactly one valid pulse; outCode = 8'h1D, makeBreak = 1, extended = 0.
REQ-032 SHALL check bytes F0, 1D -> no pulse on F0, then one valid; outCode = 8'h1D, makeBreak = 0.
REQ-033 SHALL check bytes E0, 75 then E0, F0, 75 -> first valid gives outCode 8'h75, makeBreak 1, extended 1; second gives makeBreak 0, extended 1.
REQ-034 SHALL check F0, then 0x1D with bad parity (0), then a good 0x1D -> frameError pulses once, no valid for the bad frame; the final valid has makeBreak = 1 (brk cleared).
REQ-035 SHALL check, with TIMEOUT_CYCLES = 20, start bit plus 3 data bits then idle for 25 cycles -> frameError pulses once; a following 0x1C (parity 0) decodes to outCode 8'h1C, makeBreak 1.
REQ-036 SHALL check reset = 0 for 1 cycle after 5 bits of a frame -> all outputs 0; the frame remainder yields no valid, and the next full 0x23 frame decodes correctly.
